// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one byte-wide UART transmitter
// among NREQ requesters, with an owner-idle timeout that reclaims the lock.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024,
   localparam int GW     = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_wr,
   input  logic              tx_busy,
   output logic              grant_valid,
   output logic [GW-1:0]     grant,
   output logic              timeout_evt
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [GW-1:0] owner, owner_nxt;
   logic [GW-1:0] last_grant, last_grant_nxt;
   logic [GW-1:0] winner;
   logic [15:0]   idle_cnt, idle_cnt_nxt;
   logic          last_seen, last_seen_nxt;
   logic          timeout_nxt;
   logic          owner_valid, owner_last, fire;
   logic [7:0]    data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[8*i +: 8];
   end

   assign owner_valid = req_valid[owner];
   assign owner_last  = req_last[owner];

   // Round-robin search starting just after the previous owner
   always_comb begin
      logic [GW-1:0] cand;
      logic          found;
      winner = last_grant;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GW'((int'(last_grant) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      idle_cnt_nxt   = idle_cnt;
      last_seen_nxt  = last_seen;
      timeout_nxt    = 1'b0;
      req_ready      = '0;
      fire           = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               owner_nxt    = winner;
               state_nxt    = SEND;
               idle_cnt_nxt = '0;
            end
         end
         SEND: begin
            req_ready[owner] = !tx_busy;
            fire             = owner_valid && !tx_busy;
            if (fire) begin
               last_seen_nxt = owner_last;
               idle_cnt_nxt  = '0;
               state_nxt     = WAIT_DONE;
            end else if (!owner_valid) begin
               // Only owner-idle cycles count; a busy UART never times out
               idle_cnt_nxt = idle_cnt + 16'd1;
               if (TIMEOUT != 0 && idle_cnt == TO_LAST) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = owner;
                  timeout_nxt    = 1'b1;
               end
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_seen) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = owner;
               end else begin
                  state_nxt = SEND;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= '0;
         last_grant  <= GW'(NREQ - 1);
         idle_cnt    <= '0;
         last_seen   <= 1'b0;
         timeout_evt <= 1'b0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         last_grant  <= last_grant_nxt;
         idle_cnt    <= idle_cnt_nxt;
         last_seen   <= last_seen_nxt;
         timeout_evt <= timeout_nxt;
      end
   end

   assign tx_wr       = fire;
   assign grant_valid = (state != IDLE);
   assign grant       = grant_valid ? owner : '0;
   assign tx_data     = (state == SEND) ? data_arr[owner] : 8'h00;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single byte-wide UART transmitter among NREQ requesters (CPU console, debug monitor, trace logger, etc.) using round-robin arbitration. Each grant is message-locked: the owner keeps the transmitter until it presents a byte flagged last, so messages never interleave. An inactivity timeout reclaims the transmitter from a stalled owner. The block connects between the requesters and the UART's tx_data/tx_wr/tx_busy port.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 1024: idle cycles an owner may hold the lock with req_valid low before forced release; 0 disables the timeout; 1..65535.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i on bits [8i+7:8i].
- req_last  in  NREQ  byte is the final byte of the message.
- req_ready  out  NREQ  one-hot; a byte transfers when req_valid[i] && req_ready[i].
- tx_data  out  8  to UART; owner's req_data, valid whenever tx_wr is high.
- tx_wr  out  1  to UART; one-cycle write strobe.
- tx_busy  in  1  from UART; high while a character is shifting out.
- grant_valid  out  1  a requester currently owns the transmitter.
- grant  out  $clog2(NREQ)  index of the owner; 0 when grant_valid is low.
- timeout_evt  out  1  one-cycle pulse when a lock is released by timeout.

## Operation
- FSM states: IDLE, SEND, WAIT_DONE. Registers: state, owner, last_grant, idle_cnt (16 bit), last_seen.
- IDLE: if any req_valid is high, the winner is the first set bit searching from last_grant+1 upward, wrapping modulo NREQ. owner <= winner, state <= SEND, idle_cnt <= 0. If none is high, stay in IDLE.
- SEND: req_ready[owner] = !tx_busy (combinational); all other req_ready bits are 0. tx_wr = req_valid[owner] && !tx_busy. On transfer: last_seen <= req_last[owner], idle_cnt <= 0, state <= WAIT_DONE.
- SEND with req_valid[owner] low: idle_cnt increments. When TIMEOUT != 0 and idle_cnt == TIMEOUT-1: state <= IDLE, last_grant <= owner, timeout_evt pulses.
- WAIT_DONE: req_ready = 0, tx_wr = 0. When tx_busy is low: if last_seen, state <= IDLE and last_grant <= owner; otherwise state <= SEND.
- Non-owner req_valid changes have no effect on the lock. Requesters hold valid, data and last stable until ready.
- grant_valid = (state != IDLE). grant = owner while grant_valid is high, otherwise 0.
- tx_data = req_data[8*owner +: 8] in SEND. Its value is irrelevant when tx_wr is low.
- Reset values: state IDLE, owner 0, last_grant NREQ-1 (requester 0 wins first), idle_cnt 0, last_seen 0. All outputs are 0: req_ready, tx_wr, grant_valid, grant, timeout_evt.
- Reset mid-message: return to IDLE immediately and drop the lock. A character already handed to the UART is the UART's concern. No byte is issued until arbitration runs again.
- tx_busy stuck high: the block waits indefinitely in SEND or WAIT_DONE. The timeout counts only owner-idle cycles, not UART-busy cycles.

## Timing
- Arbitration latency: request seen in IDLE at cycle T. SEND starts at T+1, and tx_wr can be high at T+1 if tx_busy is low.
- The UART registers tx_busy high on the edge after tx_wr. WAIT_DONE therefore sees tx_busy high from its first cycle. No extra guard state is needed.
- Back-to-back bytes in one message: the next tx_wr comes 1 cycle after tx_busy falls (WAIT_DONE to SEND, then transfer).
- Release on last: IDLE is entered the cycle after tx_busy falls. The next owner's first tx_wr comes 2 cycles after that.
- At most one tx_wr per character. Never assert tx_wr while tx_busy is high.

## Test plan
- Single requester 1 sends 0x41,0x42,0x43 (last on 0x43), UART model busy 20 cycles per byte -> exactly three tx_wr pulses with tx_data 0x41,0x42,0x43, grant=1 throughout, grant_valid drops after the third busy ends.
- Requesters 0 and 2 raise 2-byte messages in the same cycle from reset -> message 0 completes fully, then message 2. No byte of 2 appears between 0's bytes.
- All four requesters assert continuously with 1-byte messages -> grant sequence 0,1,2,3,0,1.
- Requester 3 is granted, sends 0x55 (not last), then drops valid; TIMEOUT=16 -> timeout_evt pulses exactly 16 idle cycles after entering SEND, lock is released, and requester 0 (waiting) is granted next.
- Reset asserted in WAIT_DONE mid-message -> next cycle all outputs are 0 and state is IDLE. After release, requester 0 wins even if requester 1 also requests.
- tx_busy held high 500 cycles with TIMEOUT=16 and owner valid high -> no tx_wr, no timeout_evt. The byte is issued the cycle tx_busy falls.
